// File: rtl/regfile_dump.sv
// regfile_dump: run monitor and register-file dumper.
//
// Waits for a start pulse, then watches the CPU program counter. The run ends when
// pc_current matches the halt PC captured at start, or when MAX_CYCLES RUN cycles
// have elapsed. When the run ends, the CPU is held and each register from the first
// index up to DUMP_LAST is read through a debug read port. Each value is streamed out
// as one valid/ready beat.
//
// Optional feature macro: REGDUMP_SKIP_ZERO_EN. When it is defined, the dump starts at
// index 1, because x0 is hardwired to zero. When it is undefined, the dump starts at
// index 0.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse, arms the monitor (ignored while busy)
//   halt_pc     in   [31:0] PC that ends the run, sampled on accepted start
//   pc_current  in   [31:0] observed CPU program counter
//   ra3         out  [4:0] register-file debug read address
//   rd3         in   [31:0] register-file debug read data (combinational from ra3)
//   halt        out  CPU hold request (FETCH, SEND, DONE)
//   dump_valid  out  dump beat available
//   dump_ready  in   sink accepts beat
//   dump_idx    out  [4:0] register index of current beat
//   dump_data   out  [31:0] register value of current beat
//   cycle_count out  [31:0] RUN cycles elapsed (saturating)
//   timeout     out  run ended by cycle budget rather than PC match
//   busy        out  high in RUN, FETCH, SEND
//   done        out  high in DONE
module regfile_dump #(
    parameter int unsigned MAX_CYCLES = 1024,
    parameter int unsigned DUMP_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] halt_pc,
    input  logic [31:0] pc_current,
    output logic [4:0]  ra3,
    input  logic [31:0] rd3,
    output logic        halt,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic [31:0] cycle_count,
    output logic        timeout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFetch,
        StSend,
        StDone
    } state_e;

`ifdef REGDUMP_SKIP_ZERO_EN
    localparam logic [4:0] FirstIdx = 5'd1;
`else
    localparam logic [4:0] FirstIdx = 5'd0;
`endif
    localparam logic [4:0]  LastIdx      = 5'(DUMP_LAST);
    // The value of cycle_count during the final budgeted RUN cycle.
    localparam logic [31:0] TimeoutCount = 32'(MAX_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] halt_pc_q, halt_pc_d;
    logic [31:0] cycle_q, cycle_d;
    logic        timeout_q, timeout_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  dump_idx_q, dump_idx_d;
    logic [31:0] dump_data_q, dump_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            halt_pc_q   <= 32'd0;
            cycle_q     <= 32'd0;
            timeout_q   <= 1'b0;
            idx_q       <= 5'd0;
            dump_idx_q  <= 5'd0;
            dump_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            halt_pc_q   <= halt_pc_d;
            cycle_q     <= cycle_d;
            timeout_q   <= timeout_d;
            idx_q       <= idx_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_pc_d   = halt_pc_q;
        cycle_d     = cycle_q;
        timeout_d   = timeout_q;
        idx_d       = idx_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    halt_pc_d = halt_pc;
                    cycle_d   = 32'd0;
                    timeout_d = 1'b0;
                    idx_d     = FirstIdx;
                    state_d   = StRun;
                end
            end
            StRun: begin
                // The cycle that ends the run is still counted.
                if (cycle_q != 32'hFFFF_FFFF) begin
                    cycle_d = cycle_q + 32'd1;
                end
                // A PC match takes priority over an expiring budget.
                if (pc_current == halt_pc_q) begin
                    state_d = StFetch;
                end else if (cycle_q == TimeoutCount) begin
                    timeout_d = 1'b1;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                // ra3 is driven with idx_q in this state, so rd3 holds that register.
                dump_idx_d  = idx_q;
                dump_data_d = rd3;
                state_d     = StSend;
            end
            StSend: begin
                if (dump_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ra3         = (state_q == StFetch) ? idx_q : 5'd0;
        halt        = (state_q == StFetch) || (state_q == StSend) || (state_q == StDone);
        busy        = (state_q == StRun) || (state_q == StFetch) || (state_q == StSend);
        done        = (state_q == StDone);
        dump_valid  = (state_q == StSend);
        dump_idx    = dump_idx_q;
        dump_data   = dump_data_q;
        cycle_count = cycle_q;
        timeout     = timeout_q;
    end

endmodule
